// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq
// Brief    : Power-good qualified reset sequencer that releases NUM_RST
//            active-low resets in ascending order with a programmable gap.
// Revision : 1.0
// ============================================================================
module rst_seq #(
    parameter int NUM_RST      = 2,
    parameter int STAGE_CYCLES = 5,
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_W        = 16
) (
    input  logic               cpu_clock,
    input  logic               cpu_rst_n,
    input  logic               pwr_ok,
    input  logic               sw_rst_req,
    input  logic [NUM_RST-1:0] hold,
    output logic [NUM_RST-1:0] rst_n_out,
    output logic               seq_busy,
    output logic               seq_done,
    output logic [7:0]         seq_count
);

    localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    localparam logic [CNT_W-1:0]   c_reload   = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [IDX_W-1:0]   c_last_idx = IDX_W'(NUM_RST - 1);
    localparam logic [NUM_RST-1:0] c_one      = NUM_RST'(1);
    localparam logic [7:0]         c_cnt_max  = 8'hFF;

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Parameter legality is enforced at elaboration time.
    generate
        if ((STAGE_CYCLES >> CNT_W) != 0) begin : g_bad_cnt_w
            $error("rst_seq: STAGE_CYCLES does not fit in CNT_W bits");
        end
        if (STAGE_CYCLES < 1) begin : g_bad_stage
            $error("rst_seq: STAGE_CYCLES must be >= 1");
        end
        if (NUM_RST < 1 || NUM_RST > 16) begin : g_bad_num
            $error("rst_seq: NUM_RST must be in 1..16");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("rst_seq: SYNC_STAGES must be >= 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_pwr_sync;
    logic                   w_pwr_s;
    logic                   w_abort;
    logic [1:0]             r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_RST-1:0]     r_rst_n;
    logic                   r_busy;
    logic                   r_done;
    logic [7:0]             r_seq_count;

    always_ff @(posedge cpu_clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_pwr_sync <= '0;
        end else begin
            r_pwr_sync <= {r_pwr_sync[SYNC_STAGES-2:0], pwr_ok};
        end
    end

    assign w_pwr_s = r_pwr_sync[SYNC_STAGES-1];
    assign w_abort = !w_pwr_s || sw_rst_req;

    // Abort is tested before release so it wins on a shared edge.
    always_ff @(posedge cpu_clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state     <= S_RESET;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_rst_n     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_seq_count <= '0;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_rst_n <= '0;
                    r_done  <= 1'b0;
                    if (!w_abort) begin
                        r_state <= S_WAIT;
                        r_cnt   <= c_reload;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (w_abort) begin
                        r_state <= S_RESET;
                        r_rst_n <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (!hold[r_idx]) begin
                        r_rst_n <= r_rst_n | (c_one << r_idx);
                        if (r_idx == c_last_idx) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            if (r_seq_count != c_cnt_max) begin
                                r_seq_count <= r_seq_count + 8'd1;
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                            r_cnt <= c_reload;
                        end
                    end
                end
                S_DONE: begin
                    if (w_abort) begin
                        r_state <= S_RESET;
                        r_rst_n <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_RESET;
                    r_rst_n <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign rst_n_out = r_rst_n;
    assign seq_busy  = r_busy;
    assign seq_done  = r_done;
    assign seq_count = r_seq_count;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq
// Brief    : Directed self-checking bench for rst_seq in two configurations
//            (2 channels / 5-cycle gap and 4 channels / 1-cycle gap).
// Revision : 1.0
// ============================================================================
module tb_rst_seq;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       a_rst_n, a_pwr_ok, a_req;
    logic [1:0] a_hold, a_out;
    logic       a_busy, a_done;
    logic [7:0] a_count;

    logic       b_rst_n, b_pwr_ok, b_req;
    logic [3:0] b_hold, b_out;
    logic       b_busy, b_done;
    logic [7:0] b_count;

    rst_seq #(.NUM_RST(2), .STAGE_CYCLES(5), .SYNC_STAGES(2), .CNT_W(16)) u_dut_a (
        .cpu_clock (clk),
        .cpu_rst_n (a_rst_n),
        .pwr_ok    (a_pwr_ok),
        .sw_rst_req(a_req),
        .hold      (a_hold),
        .rst_n_out (a_out),
        .seq_busy  (a_busy),
        .seq_done  (a_done),
        .seq_count (a_count)
    );

    rst_seq #(.NUM_RST(4), .STAGE_CYCLES(1), .SYNC_STAGES(2), .CNT_W(16)) u_dut_b (
        .cpu_clock (clk),
        .cpu_rst_n (b_rst_n),
        .pwr_ok    (b_pwr_ok),
        .sw_rst_req(b_req),
        .hold      (b_hold),
        .rst_n_out (b_out),
        .seq_busy  (b_busy),
        .seq_done  (b_done),
        .seq_count (b_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_a(input string tag, input logic [1:0] out, input logic busy,
                           input logic done, input logic [7:0] cnt);
        check({tag, "_out"},   {30'd0, a_out}, {30'd0, out});
        check({tag, "_busy"},  {31'd0, a_busy}, {31'd0, busy});
        check({tag, "_done"},  {31'd0, a_done}, {31'd0, done});
        check({tag, "_count"}, {24'd0, a_count}, {24'd0, cnt});
    endtask

    task automatic run_a_from_wait(input logic [7:0] cnt_after);
        tick(4);
        check_a("a_pre_ch0", 2'b00, 1'b1, 1'b0, cnt_after - 8'd1);
        tick(1);
        check_a("a_ch0", 2'b01, 1'b1, 1'b0, cnt_after - 8'd1);
        tick(4);
        check_a("a_pre_ch1", 2'b01, 1'b1, 1'b0, cnt_after - 8'd1);
        tick(1);
        check_a("a_ch1", 2'b11, 1'b0, 1'b1, cnt_after);
    endtask

    task automatic sw_pulse_a;
        a_req = 1'b1;
        tick(1);
        a_req = 1'b0;
    endtask

    initial begin
        a_rst_n = 1'b0; a_pwr_ok = 1'b1; a_req = 1'b0; a_hold = 2'b00;
        b_rst_n = 1'b0; b_pwr_ok = 1'b1; b_req = 1'b0; b_hold = 4'b0000;

        tick(2);
        check_a("a_reset", 2'b00, 1'b0, 1'b0, 8'd0);

        // Basic sequence: WAIT entered on the 3rd edge after reset release.
        a_rst_n = 1'b1;
        tick(2);
        check_a("a_sync", 2'b00, 1'b0, 1'b0, 8'd0);
        tick(1);
        check_a("a_wait", 2'b00, 1'b1, 1'b0, 8'd0);
        run_a_from_wait(8'd1);

        // Software re-trigger from DONE.
        sw_pulse_a();
        check_a("a_sw_abort", 2'b00, 1'b0, 1'b0, 8'd1);
        tick(1);
        check_a("a_sw_wait", 2'b00, 1'b1, 1'b0, 8'd1);
        run_a_from_wait(8'd2);

        // Hold-off on channel 1.
        a_hold = 2'b10;
        sw_pulse_a();
        tick(1);
        tick(5);
        check_a("a_hold_ch0", 2'b01, 1'b1, 1'b0, 8'd2);
        tick(20);
        check_a("a_hold_20", 2'b01, 1'b1, 1'b0, 8'd2);
        a_hold = 2'b00;
        tick(1);
        check_a("a_hold_rel", 2'b11, 1'b0, 1'b1, 8'd3);

        // Power-good drop mid-sequence.
        sw_pulse_a();
        tick(1);
        tick(5);
        check_a("a_pwr_ch0", 2'b01, 1'b1, 1'b0, 8'd3);
        a_pwr_ok = 1'b0;
        tick(2);
        check_a("a_pwr_sync", 2'b01, 1'b1, 1'b0, 8'd3);
        tick(1);
        check_a("a_pwr_abort", 2'b00, 1'b0, 1'b0, 8'd3);
        tick(3);
        check_a("a_pwr_low", 2'b00, 1'b0, 1'b0, 8'd3);
        a_pwr_ok = 1'b1;
        tick(2);
        check_a("a_pwr_resync", 2'b00, 1'b0, 1'b0, 8'd3);
        tick(1);
        check_a("a_pwr_wait", 2'b00, 1'b1, 1'b0, 8'd3);
        run_a_from_wait(8'd4);

        // Asynchronous reset in the middle of WAIT.
        sw_pulse_a();
        tick(1);
        tick(6);
        check_a("a_pre_async", 2'b01, 1'b1, 1'b0, 8'd4);
        #3;
        a_rst_n = 1'b0;
        #1;
        check_a("a_async", 2'b00, 1'b0, 1'b0, 8'd0);

        // Four channels, one-cycle gap: consecutive releases and saturation.
        b_rst_n = 1'b1;
        tick(3);
        check("b_wait_busy", {31'd0, b_busy}, 32'd1);
        check("b_wait_out",  {28'd0, b_out}, 32'h0);
        tick(1);
        check("b_step1", {28'd0, b_out}, 32'h1);
        tick(1);
        check("b_step2", {28'd0, b_out}, 32'h3);
        tick(1);
        check("b_step3", {28'd0, b_out}, 32'h7);
        tick(1);
        check("b_step4", {28'd0, b_out}, 32'hF);
        check("b_done1", {31'd0, b_done}, 32'd1);
        check("b_count1", {24'd0, b_count}, 32'd1);
        for (int i = 0; i < 259; i++) begin
            b_req = 1'b1;
            tick(1);
            b_req = 1'b0;
            check("b_loop_abort", {28'd0, b_out}, 32'h0);
            tick(5);
            check("b_loop_out", {28'd0, b_out}, 32'hF);
            check("b_loop_count", {24'd0, b_count}, (i + 2 > 255) ? 32'd255 : 32'(i + 2));
        end
        check("b_sat_done", {31'd0, b_done}, 32'd1);
        check("b_sat_count", {24'd0, b_count}, 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Parametrised, synthesizable reset sequencer. It generalises the bench's fixed "release JTAG reset, wait, release CPU reset" ordering.
- Drives NUM_RST active-low reset outputs and releases them in ascending index order, with a programmable cycle gap between releases.
- Adds behaviour the bench ordering lacks:
  - power-good qualification;
  - software re-trigger;
  - per-channel release hold-off;
  - completion status and a sequence counter.
- Sits between board clock/reset logic and the chip-level reset inputs (channel 0 = debug/JTAG domain, channel 1 = core, further channels = peripherals).

Parameters:
- NUM_RST, 2, number of sequenced reset outputs (1..16).
- STAGE_CYCLES, 5, cpu_clock cycles between successive releases (>=1).
- SYNC_STAGES, 2, flip-flop depth of the pwr_ok synchroniser (>=2).
- CNT_W, 16, width of the stage counter. STAGE_CYCLES must be < 2**CNT_W; violation is an elaboration error.

Ports:
- cpu_clock  input  1  sequencer clock.
- cpu_rst_n  input  1  asynchronous, active-low reset; asserts all outputs immediately.
- pwr_ok  input  1  asynchronous power-good; synchronised internally.
- sw_rst_req  input  1  synchronous single-cycle request to re-run the full sequence.
- hold  input  NUM_RST  per-channel hold-off; while hold[k]=1, channel k is not released.
- rst_n_out  output  NUM_RST  sequenced active-low resets; bit k is released k-th.
- seq_busy  output  1  high while a sequence is in progress (WAIT state).
- seq_done  output  1  high while all channels are released (DONE state).
- seq_count  output  8  number of completed sequences; saturates at 255.

Behaviour:
- Clock and reset: one clock, cpu_clock. cpu_rst_n is asynchronous and active-low.
- Values while cpu_rst_n=0:
  - rst_n_out = all zeros, seq_busy = 0, seq_done = 0, seq_count = 0;
  - synchroniser flops = 0; state = RESET; channel index idx = 0; counter = 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- pwr_s is pwr_ok after SYNC_STAGES flops. Only pwr_s is used internally.
- RESET state:
  - rst_n_out = 0, seq_busy = 0, seq_done = 0.
  - If pwr_s=1 and sw_rst_req=0: go to WAIT, load counter = STAGE_CYCLES-1, idx = 0.
- WAIT state (seq_busy = 1):
  - If counter != 0: decrement.
  - If counter == 0 and hold[idx] = 0: set rst_n_out[idx] = 1.
    - If idx == NUM_RST-1: go to DONE.
    - Otherwise: idx += 1 and reload counter = STAGE_CYCLES-1.
  - If counter == 0 and hold[idx] = 1: stay with counter at 0. The release occurs on the first edge with hold[idx] = 0.
  - hold on channels other than idx is ignored. Already-released channels are never re-asserted by hold.
- Release timing with no hold: rst_n_out[k] rises at the (k+1)*STAGE_CYCLES-th edge after the RESET->WAIT edge.
- DONE state:
  - rst_n_out = all ones, seq_busy = 0, seq_done = 1.
  - seq_count increments by 1 on the WAIT->DONE edge (saturating at 255).
- Abort, from any non-RESET state, when pwr_s=0 or sw_rst_req=1 is sampled:
  - next edge: rst_n_out = all zeros, seq_busy = 0, seq_done = 0, state = RESET;
  - an aborted sequence does not increment seq_count.
- Abort has priority over release on the same edge.
- sw_rst_req in RESET keeps the block in RESET for that cycle.
- If pwr_s is already 1, the sequence restarts on the next edge after the request drops.
- Every channel is asserted in the same cycle. Only release is staggered.
- NUM_RST=1: a single release at STAGE_CYCLES edges after leaving RESET.
- STAGE_CYCLES=1: releases occur on consecutive edges.

Test Plan:
- NUM_RST=2, STAGE_CYCLES=5, SYNC_STAGES=2, pwr_ok=1 from time 0, deassert cpu_rst_n → RESET->WAIT on the 3rd edge; rst_n_out = 01 five edges later, 11 five edges after that; seq_done=1 and seq_count=1 on the same edge.
- Same configuration, hold[1]=1 held for 20 cycles past channel 0 release → rst_n_out stays 01 and seq_busy=1 until the first edge after hold[1] falls, then 11 and seq_done=1.
- Pulse sw_rst_req for one cycle in DONE → next edge rst_n_out=00, seq_done=0; full sequence re-runs with identical timing; seq_count=2.
- Drop pwr_ok mid-sequence (after channel 0 released) → rst_n_out=00 two sync edges plus one edge later; seq_count unchanged; sequence restarts when pwr_ok returns.
- Assert cpu_rst_n=0 asynchronously mid-WAIT (between clock edges) → all outputs zero immediately, with no clock edge required; seq_count=0.
- NUM_RST=4, STAGE_CYCLES=1 → rst_n_out steps 0001, 0011, 0111, 1111 on four consecutive edges; 255+ sequences keep seq_count at 255.
